p2_seq_shifter: RTL and testbench

Parametrised, iterative multi-mode shifter that moves one bit position per clock. It generalises the combinational LLS/RLS/LAS/RAS decoder shifters to a WIDTH-bit datapath, adds rotate modes and an arithmetic-overflow flag, and uses a valid/ready handshake on both sides. It sits between a register-file read port and an ALU result mux, where area matters more than latency.

---
 rtl/p2_seq_shifter.sv | 148 ++++++++++++++
 tb/tb_p2_seq_shifter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p2_seq_shifter.sv
// p2_seq_shifter: iterative multi-mode shifter that moves one bit position per clock.
// Modes: 0 LLS, 1 RLS, 2 LAS, 3 RAS, 4 ROL, 5 ROR; 6/7 are reserved and flag err.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   data_in, amt, mode  operand, unsigned amount, operation select
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   data_out            result, held stable in DONE until accepted
//   ovf                 sticky LAS overflow
//   err                 reserved mode requested
module p2_seq_shifter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   amt,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             ovf,
    output logic             err
);

    localparam int unsigned LW = $clog2(WIDTH);
    localparam int unsigned CW = SHW;

    localparam logic [2:0] M_LLS = 3'd0;
    localparam logic [2:0] M_RLS = 3'd1;
    localparam logic [2:0] M_LAS = 3'd2;
    localparam logic [2:0] M_RAS = 3'd3;
    localparam logic [2:0] M_ROL = 3'd4;
    localparam logic [2:0] M_ROR = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] step_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_init_d;
    logic [2:0]       mode_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             ovf_q;
    logic             err_q;
    logic             las_step_ovf_d;

    // Iteration count for a new request: shifts clamp at WIDTH, rotates wrap.
    always_comb begin
        cnt_init_d = '0;
        case (mode)
            M_LLS, M_RLS, M_LAS, M_RAS:
                cnt_init_d = (amt >= SHW'(WIDTH)) ? CW'(WIDTH) : CW'(amt);
            M_ROL, M_ROR:
                cnt_init_d = CW'(amt[LW-1:0]);
            default:
                cnt_init_d = '0;
        endcase
    end

    // One single-bit step of the working register for the latched mode.
    always_comb begin
        step_d = data_q;
        case (mode_q)
            M_LLS, M_LAS: step_d = {data_q[WIDTH-2:0], 1'b0};
            M_RLS:        step_d = {1'b0, data_q[WIDTH-1:1]};
            M_RAS:        step_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            M_ROL:        step_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            M_ROR:        step_d = {data_q[0], data_q[WIDTH-1:1]};
            default:      step_d = data_q;
        endcase
    end

    // A left arithmetic step overflows when the sign would change.
    assign las_step_ovf_d = (mode_q == M_LAS) && (data_q[WIDTH-1] != data_q[WIDTH-2]);

    // Control FSM with registered handshake flags kept in lockstep with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= M_LLS;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        data_q     <= data_in;
                        mode_q     <= mode;
                        cnt_q      <= cnt_init_d;
                        ovf_q      <= 1'b0;
                        err_q      <= mode[2] & mode[1];
                        in_ready_q <= 1'b0;
                        if (cnt_init_d == '0) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    data_q <= step_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (las_step_ovf_d) begin
                        ovf_q <= 1'b1;
                    end
                    if (cnt_q == CW'(1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_p2_seq_shifter.sv
// Directed self-checking bench for p2_seq_shifter at WIDTH=8.
module tb_p2_seq_shifter;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic [3:0] amt;
    logic [2:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_out;
    logic       ovf;
    logic       err;

    int errors = 0;
    int checks = 0;

    p2_seq_shifter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .amt       (amt),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .ovf       (ovf),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request, let it be accepted, and count edges until out_valid.
    // lat = -1 when out_valid never arrives within the budget.
    task automatic do_req(input logic [7:0] d, input logic [3:0] a, input logic [2:0] m,
                          output int lat);
        @(negedge clk);
        data_in  = d;
        amt      = a;
        mode     = m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    // Complete the output handshake with a one-cycle out_ready pulse.
    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 8'h00 ||
            ovf !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b d=%h ovf=%b err=%b, want 1 0 00 0 0",
                     in_ready, out_valid, data_out, ovf, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lls_ras();
        int lat;
        do_req(8'b1010_0100, 4'd3, 3'd0, lat);
        checks++;
        if (data_out !== 8'b0010_0000 || ovf !== 1'b0 || err !== 1'b0 || lat !== 3) begin
            errors++;
            $display("FAIL lls3: d=%b ovf=%b err=%b lat=%0d, want 00100000 0 0 3",
                     data_out, ovf, err, lat);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL lls3_in_ready: got %b want 0", in_ready);
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lls3_handshake: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        do_req(8'b1010_0100, 4'd2, 3'd3, lat);
        checks++;
        if (data_out !== 8'b1110_1001 || ovf !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL ras2: d=%b ovf=%b lat=%0d, want 11101001 0 2", data_out, ovf, lat);
        end
        release_out();
    endtask

    task automatic test_las();
        int lat;
        do_req(8'b1010_0100, 4'd1, 3'd2, lat);
        checks++;
        if (data_out !== 8'b0100_1000 || ovf !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL las1_ovf: d=%b ovf=%b lat=%0d, want 01001000 1 1", data_out, ovf, lat);
        end
        release_out();
        do_req(8'b1100_0000, 4'd1, 3'd2, lat);
        checks++;
        if (data_out !== 8'b1000_0000 || ovf !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL las1_noovf: d=%b ovf=%b lat=%0d, want 10000000 0 1", data_out, ovf, lat);
        end
        release_out();
    endtask

    task automatic test_rotate();
        int lat;
        do_req(8'b1010_0100, 4'd3, 3'd4, lat);
        checks++;
        if (data_out !== 8'b0010_0101 || ovf !== 1'b0 || lat !== 3) begin
            errors++;
            $display("FAIL rol3: d=%b ovf=%b lat=%0d, want 00100101 0 3", data_out, ovf, lat);
        end
        release_out();
        do_req(8'b1010_0100, 4'd10, 3'd5, lat);
        checks++;
        if (data_out !== 8'b0010_1001 || lat !== 2) begin
            errors++;
            $display("FAIL ror10: d=%b lat=%0d, want 00101001 2", data_out, lat);
        end
        release_out();
        do_req(8'b1010_0100, 4'd8, 3'd4, lat);
        checks++;
        if (data_out !== 8'b1010_0100 || err !== 1'b0 || lat !== 0) begin
            errors++;
            $display("FAIL rol8: d=%b err=%b lat=%0d, want 10100100 0 0", data_out, err, lat);
        end
        release_out();
    endtask

    task automatic test_clamp();
        int lat;
        do_req(8'b1010_0100, 4'd9, 3'd1, lat);
        checks++;
        if (data_out !== 8'h00 || lat !== 8) begin
            errors++;
            $display("FAIL rls9: d=%h lat=%0d, want 00 8", data_out, lat);
        end
        release_out();
        do_req(8'b1010_0100, 4'd15, 3'd3, lat);
        checks++;
        if (data_out !== 8'hFF || lat !== 8) begin
            errors++;
            $display("FAIL ras15: d=%h lat=%0d, want ff 8", data_out, lat);
        end
        release_out();
        do_req(8'b1010_0100, 4'd5, 3'd6, lat);
        checks++;
        if (data_out !== 8'b1010_0100 || err !== 1'b1 || ovf !== 1'b0 || lat !== 0) begin
            errors++;
            $display("FAIL mode6: d=%b err=%b ovf=%b lat=%0d, want 10100100 1 0 0",
                     data_out, err, ovf, lat);
        end
        release_out();
        do_req(8'b0011_1100, 4'd1, 3'd0, lat);
        checks++;
        if (err !== 1'b0 || data_out !== 8'b0111_1000 || lat !== 1) begin
            errors++;
            $display("FAIL err_clear: err=%b d=%b lat=%0d, want 0 01111000 1", err, data_out, lat);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        do_req(8'b1010_0100, 4'd1, 3'd2, lat);
        checks++;
        if (data_out !== 8'b0100_1000 || ovf !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL bp_setup: d=%b ovf=%b lat=%0d", data_out, ovf, lat);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            data_in  = 8'hFF;
            amt      = 4'd1;
            mode     = 3'd1;
            @(negedge clk);
            checks++;
            if (data_out !== 8'b0100_1000 || ovf !== 1'b1 || out_valid !== 1'b1 ||
                in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: d=%b ovf=%b vld=%b rdy=%b, want 01001000 1 1 0",
                         i, data_out, ovf, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        release_out();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_queue: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit saw_valid;
        @(negedge clk);
        data_in  = 8'b1010_0100;
        amt      = 4'd7;
        mode     = 3'd0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 8'h00 ||
            ovf !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: rdy=%b vld=%b d=%h ovf=%b err=%b, want 1 0 00 0 0",
                     in_ready, out_valid, data_out, ovf, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard: out_valid seen=%b want 0", saw_valid);
        end
        do_req(8'h01, 4'd7, 3'd0, lat);
        checks++;
        if (data_out !== 8'h80 || lat !== 7) begin
            errors++;
            $display("FAIL rst_next: d=%h lat=%0d, want 80 7", data_out, lat);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b1;
        do_req(8'b1010_0100, 4'd3, 3'd4, lat);
        checks++;
        if (data_out !== 8'b0010_0101 || lat !== 3) begin
            errors++;
            $display("FAIL b2b_first: d=%b lat=%0d, want 00100101 3", data_out, lat);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_turn: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        do_req(8'b1100_0000, 4'd1, 3'd2, lat);
        checks++;
        if (data_out !== 8'b1000_0000 || ovf !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL b2b_second: d=%b ovf=%b lat=%0d, want 10000000 0 1",
                     data_out, ovf, lat);
        end
        release_out();
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = 8'h00;
        amt       = 4'd0;
        mode      = 3'd0;
        test_reset();
        test_lls_ras();
        test_las();
        test_rotate();
        test_clamp();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
